// File: rtl/mem_arbiter_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg : shared types and encodings for the SRAM arbiter        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  localparam int ACC_W = 16;

  typedef logic [ACC_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/mem_arbiter_if.sv
// +----------------------------------------------------------------------+
// | mem_arbiter_if : fetch, data-stage and SRAM bus signals of arbiter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic  if_req_i;
  word_t if_addr_i;
  word_t if_data_o;
  logic  if_ack_o;

  logic  dm_req_i;
  logic  dm_we_i;
  word_t dm_addr_i;
  word_t dm_wdata_i;
  word_t dm_rdata_o;
  logic  dm_ack_o;

  logic  stall_pc_o;

  word_t ram_addr_o;
  word_t ram_wdata_o;
  word_t ram_rdata_i;
  logic  ram_ce_n_o;
  logic  ram_oe_n_o;
  logic  ram_we_n_o;

  modport slave (
    input  if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, ram_rdata_i,
    output if_data_o, if_ack_o, dm_rdata_o, dm_ack_o, stall_pc_o,
           ram_addr_o, ram_wdata_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
  );

  modport master (
    output if_req_i, if_addr_i, dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i, ram_rdata_i,
    input  if_data_o, if_ack_o, dm_rdata_o, dm_ack_o, stall_pc_o,
           ram_addr_o, ram_wdata_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o
  );

endinterface

`default_nettype wire

// File: rtl/mem_wait_ctr.sv
// +----------------------------------------------------------------------+
// | mem_wait_ctr : loadable wait-state down-counter with zero flag       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_wait_ctr #(
  parameter int WIDTH = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_arbiter : fetch / data-stage arbiter for a single-port SRAM      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYC   = 1,
  parameter int STARVE_MAX = 2
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] c_st_idle    = 2'(IDLE);
  localparam logic [1:0] c_st_access  = 2'(ACCESS);
  localparam logic [1:0] c_st_done    = 2'(DONE);
  localparam logic [2:0] c_wait_ld    = 3'(WAIT_CYC);
  localparam logic [1:0] c_starve_max = 2'(STARVE_MAX);

  logic [1:0] r_state;
  logic       r_owner;
  logic       r_we;
  word_t      r_addr;
  word_t      r_wdata;
  word_t      r_if_data;
  word_t      r_dm_rdata;
  logic       r_if_ack;
  logic       r_dm_ack;
  logic [1:0] r_starve;

  logic w_grant_dm;
  logic w_grant_if;
  logic w_grant;
  logic w_access;
  logic w_zero;

  // Data stage wins unless the fetch has already been passed over STARVE_MAX times.
  assign w_grant_dm = bus.dm_req_i & (~bus.if_req_i | (r_starve != c_starve_max));
  assign w_grant_if = bus.if_req_i & ~w_grant_dm;
  assign w_grant    = (r_state == c_st_idle) & (bus.dm_req_i | bus.if_req_i);
  assign w_access   = (r_state == c_st_access);

  mem_wait_ctr #(
    .WIDTH(3)
  ) u_wait_ctr (
    .CLK       (CLK),
    .RST       (RST),
    .i_load    (w_grant),
    .i_dec     (w_access),
    .i_load_val(c_wait_ld),
    .o_zero    (w_zero)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= c_st_idle;
      r_owner    <= OWN_IF;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_if_data  <= '0;
      r_dm_rdata <= '0;
      r_if_ack   <= 1'b0;
      r_dm_ack   <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_dm_ack <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (w_grant) begin
            r_state <= c_st_access;
            r_owner <= w_grant_dm ? OWN_DM : OWN_IF;
            r_addr  <= w_grant_dm ? bus.dm_addr_i : bus.if_addr_i;
            r_we    <= w_grant_dm & bus.dm_we_i;
            r_wdata <= w_grant_dm ? bus.dm_wdata_i : '0;
            if (w_grant_if) begin
              r_starve <= '0;
            end else if (bus.if_req_i && (r_starve != c_starve_max)) begin
              r_starve <= r_starve + 2'd1;
            end
          end
        end
        c_st_access: begin
          // Last wait cycle: capture read data so it is valid alongside the ack.
          if (w_zero) begin
            r_state <= c_st_done;
            if (r_owner == OWN_IF) begin
              r_if_data <= bus.ram_rdata_i;
              r_if_ack  <= 1'b1;
            end else begin
              r_dm_ack <= 1'b1;
              if (!r_we) begin
                r_dm_rdata <= bus.ram_rdata_i;
              end
            end
          end
        end
        c_st_done: begin
          r_state <= c_st_idle;
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

  assign bus.if_data_o   = r_if_data;
  assign bus.if_ack_o    = r_if_ack;
  assign bus.dm_rdata_o  = r_dm_rdata;
  assign bus.dm_ack_o    = r_dm_ack;
  assign bus.stall_pc_o  = bus.if_req_i & ~r_if_ack;
  assign bus.ram_addr_o  = r_addr;
  assign bus.ram_wdata_o = r_wdata;
  assign bus.ram_ce_n_o  = ~w_access;
  assign bus.ram_oe_n_o  = ~(w_access & ~r_we);
  assign bus.ram_we_n_o  = ~(w_access & r_we);

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_arbiter : self-checking bench, SRAM model plus ack scoreboard |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  mem_arbiter_if b1();
  mem_arbiter_if b0();

  mem_arbiter #(.WAIT_CYC(1), .STARVE_MAX(2)) u_dut1 (.CLK(CLK), .RST(RST), .bus(b1.slave));
  mem_arbiter #(.WAIT_CYC(0), .STARVE_MAX(2)) u_dut0 (.CLK(CLK), .RST(RST), .bus(b0.slave));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // SRAM model: mem[i] = (i*0x0101)^0x5A5A, except mem[0x10] = 0x1234; reloaded during reset.
  logic [15:0] mem1 [0:255];
  function automatic logic [15:0] f_init(input int i);
    logic [15:0] v;
    v = 16'(i) * 16'h0101;
    return (i == 16) ? 16'h1234 : (v ^ 16'h5A5A);
  endfunction

  always @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < 256; i++) mem1[i] <= f_init(i);
    end else if (!b1.ram_ce_n_o && !b1.ram_we_n_o) begin
      mem1[b1.ram_addr_o[7:0]] <= b1.ram_wdata_o;
    end
  end

  assign b1.ram_rdata_i = b1.ram_oe_n_o ? 16'hDEAD : mem1[b1.ram_addr_o[7:0]];
  assign b0.ram_rdata_i = b0.ram_oe_n_o ? 16'hDEAD : (b0.ram_addr_o ^ 16'hA5A5);

  // Scoreboard: one entry pushed per request, popped when its ack appears.
  typedef struct {bit cmp; logic [15:0] data;} sb_t;
  sb_t q_if1[$];
  sb_t q_dm1[$];
  sb_t q_if0[$];
  logic prev_if1, prev_dm1, prev_if0;

  always @(negedge CLK) begin
    sb_t e;
    if (b1.if_ack_o === 1'b1) begin
      chk("if1_ack_pulse", prev_if1, 1'b0);
      if (q_if1.size() == 0) chk("if1_unexpected_ack", 32'(q_if1.size()), 32'd1);
      else begin
        e = q_if1.pop_front();
        if (e.cmp) chk("if1_data", b1.if_data_o, e.data);
      end
    end
    if (b1.dm_ack_o === 1'b1) begin
      chk("dm1_ack_pulse", prev_dm1, 1'b0);
      if (q_dm1.size() == 0) chk("dm1_unexpected_ack", 32'(q_dm1.size()), 32'd1);
      else begin
        e = q_dm1.pop_front();
        if (e.cmp) chk("dm1_rdata", b1.dm_rdata_o, e.data);
      end
    end
    if (b0.if_ack_o === 1'b1) begin
      chk("if0_ack_pulse", prev_if0, 1'b0);
      if (q_if0.size() == 0) chk("if0_unexpected_ack", 32'(q_if0.size()), 32'd1);
      else begin
        e = q_if0.pop_front();
        if (e.cmp) chk("if0_data", b0.if_data_o, e.data);
      end
    end
    prev_if1 = b1.if_ack_o;
    prev_dm1 = b1.dm_ack_o;
    prev_if0 = b0.if_ack_o;
  end

  // Single access on dut1 (WAIT_CYC=1): ack three cycles after the request, two strobe cycles.
  task automatic do_single(input string tag, input bit is_dm, input bit we,
                           input logic [15:0] addr, input logic [15:0] wd, input logic [15:0] exp_rd);
    sb_t e;
    int  lat, we_lo, oe_lo, ce_lo;
    bit  got;
    e.cmp  = !we;
    e.data = exp_rd;
    if (is_dm) begin
      q_dm1.push_back(e);
      b1.dm_req_i = 1'b1; b1.dm_we_i = we; b1.dm_addr_i = addr; b1.dm_wdata_i = wd;
    end else begin
      q_if1.push_back(e);
      b1.if_req_i = 1'b1; b1.if_addr_i = addr;
    end
    #1;
    if (!is_dm) chk({tag, "_stall0"}, b1.stall_pc_o, 1'b1);
    got = 0; lat = 0; we_lo = 0; oe_lo = 0; ce_lo = 0;
    while (!got && lat < 20) begin
      @(negedge CLK);
      lat++;
      we_lo += int'(!b1.ram_we_n_o);
      oe_lo += int'(!b1.ram_oe_n_o);
      ce_lo += int'(!b1.ram_ce_n_o);
      if (!b1.ram_ce_n_o) chk({tag, "_ram_addr"}, b1.ram_addr_o, addr);
      got = is_dm ? b1.dm_ack_o : b1.if_ack_o;
      if (!is_dm) chk({tag, "_stall"}, b1.stall_pc_o, !got);
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_we_cycles"}, we_lo, we ? 2 : 0);
    chk({tag, "_oe_cycles"}, oe_lo, we ? 0 : 2);
    chk({tag, "_ce_cycles"}, ce_lo, 2);
    b1.dm_req_i = 1'b0; b1.dm_we_i = 1'b0; b1.if_req_i = 1'b0;
    @(negedge CLK);
  endtask

  typedef struct {bit is_dm; bit we; logic [15:0] addr; logic [15:0] wdata; logic [15:0] exp_rd;} vec_t;
  vec_t vt[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sb_t        e;
    int         t, dm_t, if_t, we_lo, n;
    int         ack_t[3];
    logic [5:0] seq, exp_seq;

    RST = 1'b1;
    b1.if_req_i = 0; b1.if_addr_i = 0; b1.dm_req_i = 0; b1.dm_we_i = 0; b1.dm_addr_i = 0; b1.dm_wdata_i = 0;
    b0.if_req_i = 0; b0.if_addr_i = 0; b0.dm_req_i = 0; b0.dm_we_i = 0; b0.dm_addr_i = 0; b0.dm_wdata_i = 0;
    repeat (3) @(negedge CLK);

    chk("rst_ce_n", b1.ram_ce_n_o, 1'b1);
    chk("rst_oe_n", b1.ram_oe_n_o, 1'b1);
    chk("rst_we_n", b1.ram_we_n_o, 1'b1);
    chk("rst_acks", {b1.if_ack_o, b1.dm_ack_o}, 2'b00);
    chk("rst_if_data", b1.if_data_o, 16'h0000);
    chk("rst_dm_rdata", b1.dm_rdata_o, 16'h0000);
    chk("rst_ram_addr", b1.ram_addr_o, 16'h0000);
    chk("rst_ram_wdata", b1.ram_wdata_o, 16'h0000);
    RST = 1'b0;
    @(negedge CLK);

    // Fetch read of 0x0010 returning 0x1234.
    do_single("fetch", 1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234);

    vt[0] = '{1'b1, 1'b1, 16'h0020, 16'hCAFE, 16'h0000};
    vt[1] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'hCAFE};
    vt[2] = '{1'b0, 1'b0, 16'h0021, 16'h0000, 16'h7B7B};
    vt[3] = '{1'b1, 1'b1, 16'h00FF, 16'h0001, 16'h0000};
    vt[4] = '{1'b1, 1'b0, 16'h00FF, 16'h0000, 16'h0001};
    vt[5] = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'hCAFE};
    vt[6] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'h5959};
    for (int i = 0; i < 7; i++) begin
      do_single($sformatf("vec%0d", i), vt[i].is_dm, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd);
    end

    // dm write and fetch in the same cycle: dm first, fetch four cycles later.
    e = '{1'b0, 16'h0000}; q_dm1.push_back(e);
    e = '{1'b1, 16'h6A6A}; q_if1.push_back(e);
    b1.dm_req_i = 1; b1.dm_we_i = 1; b1.dm_addr_i = 16'h0200; b1.dm_wdata_i = 16'hBEEF;
    b1.if_req_i = 1; b1.if_addr_i = 16'h0030;
    t = 0; dm_t = -1; if_t = -1; we_lo = 0;
    while (if_t < 0 && t < 30) begin
      @(negedge CLK);
      t++;
      if (!b1.ram_we_n_o) begin
        we_lo++;
        chk("both_waddr", b1.ram_addr_o, 16'h0200);
        chk("both_wdata", b1.ram_wdata_o, 16'hBEEF);
      end
      if (b1.dm_ack_o) begin dm_t = t; b1.dm_req_i = 0; b1.dm_we_i = 0; end
      if (b1.if_ack_o) begin if_t = t; b1.if_req_i = 0; end
    end
    chk("both_dm_ack_cyc", dm_t, 3);
    chk("both_if_after_dm", if_t - dm_t, 4);
    chk("both_we_cycles", we_lo, 2);
    @(negedge CLK);

    // Continuous contention: dm, dm, if, dm, dm, if.
    for (int i = 0; i < 4; i++) begin e = '{1'b1, 16'hBEEF}; q_dm1.push_back(e); end
    for (int i = 0; i < 2; i++) begin e = '{1'b1, 16'h0A0A}; q_if1.push_back(e); end
    b1.dm_req_i = 1; b1.dm_we_i = 0; b1.dm_addr_i = 16'h0000;
    b1.if_req_i = 1; b1.if_addr_i = 16'h0050;
    n = 0; t = 0; seq = '0; exp_seq = 6'b011011;
    while (n < 6 && t < 60) begin
      @(negedge CLK);
      t++;
      if (b1.dm_ack_o) begin seq[n] = 1'b1; n++; end
      if (b1.if_ack_o) begin seq[n] = 1'b0; n++; end
      if (n >= 6) begin b1.dm_req_i = 0; b1.if_req_i = 0; end
    end
    chk("starve_grant_count", n, 6);
    for (int k = 0; k < 6; k++) chk($sformatf("starve_grant%0d", k), seq[k], exp_seq[k]);
    b1.dm_req_i = 0; b1.if_req_i = 0;
    @(negedge CLK);

    // Reset on the second ACCESS cycle of a dm read aborts it.
    b1.dm_req_i = 1; b1.dm_we_i = 0; b1.dm_addr_i = 16'h0060;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1; b1.dm_req_i = 0;
    @(negedge CLK);
    chk("abort_strobes", {b1.ram_ce_n_o, b1.ram_oe_n_o, b1.ram_we_n_o}, 3'b111);
    chk("abort_dm_ack", b1.dm_ack_o, 1'b0);
    chk("abort_outputs", {b1.if_data_o, b1.dm_rdata_o}, 32'h0);
    chk("abort_ram_addr", b1.ram_addr_o, 16'h0000);
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("abort_no_ack", b1.dm_ack_o, 1'b0);
    end
    do_single("post_abort", 1'b1, 1'b0, 16'h0061, 16'h0000, 16'h3B3B);

    // WAIT_CYC=0 back-to-back fetches of addresses 0,1,2.
    for (int i = 0; i < 3; i++) begin e = '{1'b1, 16'(i) ^ 16'hA5A5}; q_if0.push_back(e); end
    b0.if_req_i = 1; b0.if_addr_i = 16'h0000;
    n = 0; t = 0;
    while (n < 3 && t < 40) begin
      @(negedge CLK);
      t++;
      if (!b0.ram_ce_n_o) chk("w0_ram_addr", b0.ram_addr_o, 16'(n));
      if (b0.if_ack_o) begin
        ack_t[n] = t;
        n++;
        if (n < 3) b0.if_addr_i = 16'(n);
        else b0.if_req_i = 0;
      end
    end
    chk("w0_ack_count", n, 3);
    chk("w0_first_ack", ack_t[0], 2);
    chk("w0_gap1", ack_t[1] - ack_t[0], 3);
    chk("w0_gap2", ack_t[2] - ack_t[1], 3);
    repeat (3) @(negedge CLK);

    chk("sb_if1_empty", 32'(q_if1.size()), 32'd0);
    chk("sb_dm1_empty", 32'(q_dm1.size()), 32'd0);
    chk("sb_if0_empty", 32'(q_if0.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYC, default 1, giving the number of extra SRAM wait cycles per access (0..7).
REQ-002 The block SHALL have parameter STARVE_MAX, default 2, giving the maximum number of consecutive data grants while a fetch waits (1..3).
REQ-003 CLK  in  1  single clock; all state changes on posedge.
REQ-004 RST  in  1  synchronous, active-high reset.
REQ-005 if_req_i  in  1  fetch read request, level, held until acked.
REQ-006 if_addr_i  in  16  fetch address (pc).
REQ-007 if_data_o  out  16  registered fetch data (instruction).
REQ-008 if_ack_o  out  1  one-cycle pulse; if_data_o valid.
REQ-009 dm_req_i  in  1  data-stage request, level, held until acked.
REQ-010 dm_we_i  in  1  1 = write, 0 = read.
REQ-011 dm_addr_i  in  16  data address.
REQ-012 dm_wdata_i  in  16  write data.
REQ-013 dm_rdata_o  out  16  registered read data.
REQ-014 dm_ack_o  out  1  one-cycle completion pulse.
REQ-015 stall_pc_o  out  1  freeze request to fetch.
REQ-016 ram_addr_o  out  16  SRAM address.
REQ-017 ram_wdata_o  out  16  SRAM write data.
REQ-018 ram_rdata_i  in  16  SRAM read data.
REQ-019 ram_ce_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  active-low SRAM strobes.

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS, DONE: IDLE->ACCESS on any request; ACCESS holds WAIT_CYC+1 cycles; then DONE; DONE->IDLE always.
REQ-021 In IDLE, the arbiter SHALL grant dm over if when both are asserted, except when starve_cnt==STARVE_MAX, in which case it SHALL grant if.
REQ-022 starve_cnt SHALL increment on a dm grant while if_req_i is high, clear on any if grant, and saturate at STARVE_MAX.
REQ-023 On grant, the arbiter SHALL latch owner, address, we and wdata; later request/address changes SHALL NOT affect the access in flight.
REQ-024 In ACCESS, ram_ce_n_o SHALL be 0; ram_oe_n_o SHALL be 0 for reads; ram_we_n_o SHALL be 0 for writes; in IDLE/DONE all strobes SHALL be 1.
REQ-025 ram_addr_o and ram_wdata_o SHALL hold the latched values from ACCESS through DONE.
REQ-026 On the last ACCESS cycle the arbiter SHALL register ram_rdata_i into the owner's data output; that output SHALL hold until the owner's next ack.
REQ-027 In DONE, the owner's ack SHALL pulse for exactly one cycle, including for writes.
REQ-028 Latency SHALL be: request seen in IDLE at cycle N gives ack at cycle N+WAIT_CYC+2; at least one IDLE turnaround cycle SHALL separate accesses.
REQ-029 A request observed in IDLE SHALL be treated as new; the requester drops or changes its request in the cycle after ack.
REQ-030 stall_pc_o SHALL equal if_req_i AND NOT if_ack_o (combinational).
REQ-031 A request that drops mid-access SHALL still complete and be acked; the ack is ignored by the requester.
REQ-032 With WAIT_CYC=0, ACCESS SHALL last exactly one cycle.

Reset
REQ-033 With RST high at a posedge, the next state SHALL be: state IDLE, starve_cnt 0, acks 0, strobes 1, if_data_o/dm_rdata_o/ram_addr_o/ram_wdata_o 16'h0000.
REQ-034 A reset mid-access SHALL abort the access with no ack and strobes deasserted from the next cycle.

Structure
REQ-035 Package mem_arb_pkg SHALL hold the state enum (IDLE/ACCESS/DONE), the owner encoding (OWN_IF=0, OWN_DM=1) and the access-width constant 16.
REQ-036 The wait-state down-counter SHALL be the one sub-module, mem_wait_ctr (load, decrement, zero flag); everything else is flat.

Verification
REQ-037 Fetch read only (WAIT_CYC=1, if_addr 16'h0010, ram_rdata 16'h1234): if_ack at cycle 3, if_data_o=16'h1234, stall_pc_o high cycles 0-2.
REQ-038 dm write and if read in the same cycle: dm granted first (we_n low 2 cycles, addr 16'h0200, data 16'hBEEF); if acked 4 cycles after dm_ack.
REQ-039 dm_req_i held continuously with if_req_i high: grants go dm, dm, if, dm, dm, if (STARVE_MAX=2).
REQ-040 RST asserted on the 2nd ACCESS cycle of a dm read: no dm_ack, all strobes 1 next cycle, state IDLE, outputs 16'h0000.
REQ-041 WAIT_CYC=0 back-to-back if reads: acks every 3 cycles; addresses 0,1,2 returned in order.
